// File: rtl/raiz_pkg.sv
// raiz_pkg: shared definitions for the parametrised square-root peripheral.
//   - Bus register byte offsets (5-bit address space).
//   - Control and status bit positions.
//   - Core FSM state encoding.
package raiz_pkg;

    localparam logic [4:0] DIR_OPERANDO = 5'h04;  // W: operand shadow
    localparam logic [4:0] DIR_CONTROL  = 5'h0C;  // W: bit0 start, bit1 clear done/error
    localparam logic [4:0] DIR_RAIZ     = 5'h10;  // R: root
    localparam logic [4:0] DIR_ESTADO   = 5'h14;  // R: status
    localparam logic [4:0] DIR_RESTO    = 5'h18;  // R: remainder (optional)

    localparam int unsigned BIT_INICIO  = 0;
    localparam int unsigned BIT_LIMPIAR = 1;

    localparam int unsigned BIT_TERMINADO = 0;
    localparam int unsigned BIT_OCUPADO   = 1;
    localparam int unsigned BIT_ERROR     = 2;

    typedef enum logic {
        INACTIVO,
        CALCULO
    } estado_t;

endpackage

// File: rtl/nucleo_raiz_n.sv
// nucleo_raiz_n: non-restoring digit-recurrence integer square root,
// one root bit per clock, ANCHO/2 iterations.
// Ports:
//   reloj, reiniciar  clock, synchronous active-high reset
//   inicio            load operando and begin (ignored while busy)
//   operando          ANCHO-bit radicand
//   raiz, resto       result; valid only while terminado is high
//   ocupado           high for the whole computation
//   terminado         one-cycle pulse on the final iteration
module nucleo_raiz_n
    import raiz_pkg::*;
#(
    parameter int unsigned ANCHO = 16
) (
    input  logic               reloj,
    input  logic               reiniciar,
    input  logic               inicio,
    input  logic [ANCHO-1:0]   operando,
    output logic [ANCHO/2-1:0] raiz,
    output logic [ANCHO/2:0]   resto,
    output logic               ocupado,
    output logic               terminado
);

    localparam int unsigned RW   = ANCHO / 2;
    localparam int unsigned ITER = RW;
    // Signed partial remainder with headroom for the shifted value.
    localparam int unsigned RR   = RW + 3;

    estado_t estado, estado_sig;

    logic [4:0]       cuenta;
    logic [ANCHO-1:0] desplazado;
    logic [RW-1:0]    q;
    logic [RR-1:0]    r;

    logic             ultima;
    logic [RR-1:0]    r_desp;
    logic [RR-1:0]    r_sig;
    logic [RW-1:0]    q_sig;

    assign ultima = (cuenta == 5'(ITER - 1));

    always_ff @(posedge reloj) begin
        if (reiniciar) begin
            estado <= INACTIVO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        ocupado    = 1'b0;
        terminado  = 1'b0;
        case (estado)
            INACTIVO: begin
                if (inicio) begin
                    estado_sig = CALCULO;
                end
            end
            CALCULO: begin
                ocupado = 1'b1;
                if (ultima) begin
                    terminado  = 1'b1;
                    estado_sig = INACTIVO;
                end
            end
            default: estado_sig = INACTIVO;
        endcase
    end

    // One recurrence step: bring down two radicand bits, then add or
    // subtract the trial term depending on the sign of the remainder.
    always_comb begin
        r_desp = (r << 2) | RR'(desplazado[ANCHO-1 -: 2]);
        if (r[RR-1]) begin
            r_sig = r_desp + RR'({q, 2'b11});
        end else begin
            r_sig = r_desp - RR'({q, 2'b01});
        end
        q_sig = RW'({q, ~r_sig[RR-1]});
        raiz  = q_sig;
        // A negative final remainder gets one restoring correction.
        if (r_sig[RR-1]) begin
            resto = r_sig[RW:0] + {q_sig, 1'b1};
        end else begin
            resto = r_sig[RW:0];
        end
    end

    always_ff @(posedge reloj) begin
        if (reiniciar) begin
            cuenta     <= '0;
            desplazado <= '0;
            q          <= '0;
            r          <= '0;
        end else if (estado == INACTIVO && inicio) begin
            cuenta     <= '0;
            desplazado <= operando;
            q          <= '0;
            r          <= '0;
        end else if (estado == CALCULO) begin
            cuenta     <= cuenta + 5'd1;
            desplazado <= desplazado << 2;
            q          <= q_sig;
            r          <= r_sig;
        end
    end

endmodule

// File: rtl/periferico_raiz_n.sv
// periferico_raiz_n: memory-mapped integer square-root peripheral.
// Ports:
//   reloj, reiniciar   clock, synchronous active-high reset
//   entrada_datos      ANCHO-bit write data
//   habilitar          chip select qualifying leer/escribir
//   direccion          5-bit register byte offset
//   leer, escribir     read/write strobes (write wins if both)
//   salida_datos       registered, zero-extended read data
//   interrupcion       level, mirrors the done flag
// Build option: define RAIZ_RESTO_EN to add the remainder register at 0x18;
// otherwise that address reads 0.
module periferico_raiz_n
    import raiz_pkg::*;
#(
    parameter int unsigned ANCHO = 16
) (
    input  logic             reloj,
    input  logic             reiniciar,
    input  logic [ANCHO-1:0] entrada_datos,
    input  logic             habilitar,
    input  logic [4:0]       direccion,
    input  logic             leer,
    input  logic             escribir,
    output logic [31:0]      salida_datos,
    output logic             interrupcion
);

    logic               escritura;
    logic               lectura;
    logic               escritura_control;
    logic               pide_inicio;
    logic               pide_limpiar;
    logic               inicio_nucleo;

    logic [ANCHO-1:0]   operando;
    logic [ANCHO/2-1:0] raiz_reg;
    logic               terminado_reg;
    logic               error_reg;

    logic [ANCHO/2-1:0] raiz_nucleo;
    logic               ocupado;
    logic               fin;
    logic [31:0]        dato_leido;

`ifdef RAIZ_RESTO_EN
    logic [ANCHO/2:0]   resto_nucleo;
    logic [ANCHO/2:0]   resto_reg;
`else
    logic [ANCHO/2:0]   resto_unused;
`endif

    assign escritura         = habilitar & escribir;
    assign lectura           = habilitar & leer & ~escribir;
    assign escritura_control = escritura && (direccion == DIR_CONTROL);
    assign pide_inicio       = escritura_control && entrada_datos[BIT_INICIO];
    assign pide_limpiar      = escritura_control && entrada_datos[BIT_LIMPIAR];
    assign inicio_nucleo     = pide_inicio && !ocupado;
    assign interrupcion      = terminado_reg;

    nucleo_raiz_n #(
        .ANCHO(ANCHO)
    ) instancia_raiz (
        .reloj     (reloj),
        .reiniciar (reiniciar),
        .inicio    (inicio_nucleo),
        .operando  (operando),
        .raiz      (raiz_nucleo),
`ifdef RAIZ_RESTO_EN
        .resto     (resto_nucleo),
`else
        .resto     (resto_unused),
`endif
        .ocupado   (ocupado),
        .terminado (fin)
    );

    // Assignment order sets priority: clear, then start, then completion.
    always_ff @(posedge reloj) begin
        if (reiniciar) begin
            operando      <= '0;
            raiz_reg      <= '0;
            terminado_reg <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            if (escritura && direccion == DIR_OPERANDO) begin
                operando <= entrada_datos;
            end
            if (pide_limpiar) begin
                terminado_reg <= 1'b0;
                error_reg     <= 1'b0;
            end
            if (pide_inicio) begin
                if (ocupado) begin
                    error_reg <= 1'b1;
                end else begin
                    terminado_reg <= 1'b0;
                end
            end
            if (fin) begin
                terminado_reg <= 1'b1;
                raiz_reg      <= raiz_nucleo;
            end
        end
    end

`ifdef RAIZ_RESTO_EN
    always_ff @(posedge reloj) begin
        if (reiniciar) begin
            resto_reg <= '0;
        end else if (fin) begin
            resto_reg <= resto_nucleo;
        end
    end
`endif

    always_comb begin
        dato_leido = '0;
        case (direccion)
            DIR_RAIZ: dato_leido = 32'(raiz_reg);
            DIR_ESTADO: begin
                dato_leido[BIT_TERMINADO] = terminado_reg;
                dato_leido[BIT_OCUPADO]   = ocupado;
                dato_leido[BIT_ERROR]     = error_reg;
            end
`ifdef RAIZ_RESTO_EN
            DIR_RESTO: dato_leido = 32'(resto_reg);
`endif
            default: dato_leido = '0;
        endcase
    end

    always_ff @(posedge reloj) begin
        if (reiniciar) begin
            salida_datos <= '0;
        end else if (lectura) begin
            salida_datos <= dato_leido;
        end
    end

endmodule
